dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter that shares the single-port 8-bit data memory between the CPU datapath and a host/debug port used to preload, inspect and patch memory while a program runs. The CPU port has priority. A starvation counter forces a host slot after a bounded wait. An optional lock mode lets the host halt the CPU and own memory for a burst. It sits between the CPU's data-address mux / regB write-data path and `data_memory`, and drives a stall line that the CPU uses to freeze PC, register loads and status updates.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `STARVE_LIMIT`, 4: consecutive contended cycles the host may lose before it is forced in. Legal range is 1..15.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU performs a memory access (load or store) this cycle.
- `cpu_we` in 1: CPU access is a store.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU store data.
- `cpu_rdata` out DATA_W: equals `mem_rdata`, combinational.
- `cpu_stall` out 1: the CPU must not commit this cycle. This gates LP, LA, LB, status load and the CPU's own write enable.
- `host_req` in 1: host access request, held until granted.
- `host_we` in 1: host access is a write.
- `host_lock` in 1: host requests exclusive ownership.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_gnt` out 1: host access is performed this cycle, combinational.
- `host_rdata` out DATA_W: registered host read data.
- `host_rvalid` out 1: one-cycle pulse, `host_rdata` valid.
- `mem_addr` out ADDR_W: address to `data_memory`.
- `mem_wdata` out DATA_W: write data to `data_memory`.
- `mem_we` out 1: write enable to `data_memory`.
- `mem_rdata` in DATA_W: asynchronous read data from `data_memory`.

## Operation
States:
- `S_CPU` (default).
- `S_FORCE` (one host-forced slot).
- `S_LOCK` (host exclusive).

Owner muxing:
- When the owner is the CPU: `mem_addr/mem_wdata = cpu_*`, `mem_we = cpu_req & cpu_we`.
- When the owner is the host: `mem_addr/mem_wdata = host_*`, `mem_we = host_gnt & host_we`.

Behaviour in `S_CPU`:
- `host_req` and not `cpu_req`: host owns the cycle and `host_gnt=1`. The starvation counter clears.
- `host_req` and `cpu_req`: CPU owns the cycle and `host_gnt=0`. The counter increments. When the counter reaches `STARVE_LIMIT`, next state is `S_FORCE`.
- `host_req` low: counter clears.
- `cpu_stall=0`.

Behaviour in `S_FORCE`:
- Host owns the cycle and `host_gnt=host_req`.
- `cpu_stall=cpu_req`.
- Counter clears.
- Next state is `S_CPU`.
- If `host_req` dropped before this slot, the slot is still consumed with no access.

Entry to `S_LOCK`:
- Any cycle with `host_gnt & host_lock` moves the next state to `S_LOCK`.

Behaviour in `S_LOCK`:
- Host owns every cycle and `host_gnt=host_req`.
- `cpu_stall=1` unconditionally.
- `host_lock=0` sampled at the clock edge moves the next state to `S_CPU`. The cycle in which `host_lock` is low is still host-owned.

Host reads:
- On a cycle with `host_gnt & ~host_we`, `mem_rdata` is captured into `host_rdata`.
- `host_rvalid` pulses on the following cycle.
- `host_rdata` holds its value until the next host read.

Other rules:
- CPU reads see memory in the same cycle. There is no added CPU latency when uncontended.
- Simultaneous CPU store and host write to the same address: only the owner writes. There is never a merged write.

## Timing
Reset (`rst_n` low, asynchronous):
- State is `S_CPU` and the counter is 0.
- `host_rdata=0` and `host_rvalid=0`.
- `host_gnt=0`, `cpu_stall=0` and `mem_we=0` are forced combinationally while reset is asserted.
- Reset mid-lock or mid-force drops `cpu_stall` immediately.

Latency:
- Host write: 0 cycles after grant.
- Host read data: 1 cycle after grant.
- Worst-case host wait under continuous CPU traffic: `STARVE_LIMIT` cycles, granted on cycle `STARVE_LIMIT`+1.

Combinational paths:
- `host_gnt`, `cpu_stall` and `mem_*` depend combinationally on `cpu_req`, `host_req` and state.
- No path exists from `mem_rdata` to any control output.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: `host_lock` is functional and `S_LOCK` exists.
- `DMEM_ARB_LOCK_EN` undefined:
  - The `host_lock` port remains but is ignored.
  - `S_LOCK` is not compiled.
  - `cpu_stall` is asserted only in `S_FORCE`.

## Structure
- Shared package `dmem_arb_pkg` contains:
  - the state enum (`S_CPU`, `S_FORCE`, `S_LOCK`);
  - the owner type (`OWN_CPU`, `OWN_HOST`);
  - default `STARVE_LIMIT`;
  - the 4-bit counter width constant.
- One sub-module, `dmem_arb_starve_cnt`: saturating counter with `inc`/`clr` inputs and a `hit` output at `STARVE_LIMIT`.

## Test plan
- **Reset:** `rst_n=0` with `host_req=1`, `host_we=1` → `mem_we=0`, `host_gnt=0`. After release, the first idle-CPU cycle grants the host.
- **Idle-CPU host access:** `cpu_req=0`, host write 0xA5 to 0x10 → `host_gnt=1`, `mem_we=1`, `mem_addr=0x10`. A following host read of 0x10 → `host_rvalid` one cycle later with `host_rdata=0xA5`.
- **Starvation:** `STARVE_LIMIT=4`, `cpu_req` and `host_req` held high → CPU owns 4 cycles, the 5th has `host_gnt=1` and `cpu_stall=1`. The pattern repeats with period 5.
- **Write collision:** CPU store 0x33 and host write 0x77 to 0x20 in the same cycle → memory holds 0x33 and the host stays ungranted.
- **Lock:** `host_lock=1` at grant → `cpu_stall=1` every cycle and only host writes reach memory. `host_lock` drops → `cpu_stall=0` on the next cycle. `rst_n` pulsed mid-lock → `cpu_stall=0` immediately.
- **Macro off:** same stimulus as the lock scenario → `cpu_stall` is never asserted outside `S_FORCE`.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a. Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_FORCE = 2'd1,
    S_LOCK  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W            = 4;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the host lost to the CPU.
// Latency: hit is combinational. Backpressure: none, inc/clr are sampled every cycle.
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;

  // hit flags the increment that brings the count up to LIMIT
  assign hit = inc && (cnt_q == LIM - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the shared data memory with host starvation slot; host lock mode under DMEM_ARB_LOCK_EN.
// Latency: grant/mux 0 cycles, host read data 1 cycle. Backpressure: host holds host_req until host_gnt; CPU freezes on cpu_stall.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state_q, state_d;
  owner_t     owner;
  logic       gnt_c, stall_c, we_c;
  logic       cnt_inc, cnt_hit;

`ifndef DMEM_ARB_LOCK_EN
  logic unused_host_lock;
  assign unused_host_lock = host_lock;
`endif

  dmem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (!cnt_inc),
    .hit   (cnt_hit)
  );

  always_comb begin
    state_d = state_q;
    owner   = OWN_CPU;
    gnt_c   = 1'b0;
    stall_c = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_CPU: begin
        if (host_req && !cpu_req) begin
          owner = OWN_HOST;
          gnt_c = 1'b1;
        end else if (host_req && cpu_req) begin
          cnt_inc = 1'b1;
          if (cnt_hit) state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        // slot is consumed even if the host has since dropped its request
        owner   = OWN_HOST;
        gnt_c   = host_req;
        stall_c = cpu_req;
        state_d = S_CPU;
      end
`ifdef DMEM_ARB_LOCK_EN
      S_LOCK: begin
        owner   = OWN_HOST;
        gnt_c   = host_req;
        stall_c = 1'b1;
        state_d = host_lock ? S_LOCK : S_CPU;
      end
`endif
      default: state_d = S_CPU;
    endcase
`ifdef DMEM_ARB_LOCK_EN
    if (gnt_c && host_lock) state_d = S_LOCK;
`endif
  end

  always_comb begin
    if (owner == OWN_HOST) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      we_c      = gnt_c && host_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      we_c      = cpu_req && cpu_we;
    end
  end

  // reset must silence every strobe at once, not one edge later
  assign host_gnt  = rst_n && gnt_c;
  assign cpu_stall = rst_n && stall_c;
  assign mem_we    = rst_n && we_c;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CPU;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      state_q     <= state_d;
      host_rvalid <= gnt_c && !host_we;
      if (gnt_c && !host_we) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: bench-side memory, per-cycle rule model, literal spot checks.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_stall, host_gnt, host_rvalid, mem_we;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  int         lost;
  bit         force_slot, locked;
  logic       exp_rv;
  logic [7:0] exp_rd;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the arbitration rules, checked every falling edge.
  always @(negedge clk) begin : model
    bit         host_own, e_gnt, e_stall, e_we;
    logic [7:0] e_addr, e_wd;
    if (!rst_n) begin
      check("rst_gnt", host_gnt, 0);
      check("rst_stall", cpu_stall, 0);
      check("rst_we", mem_we, 0);
      check("rst_rvalid", host_rvalid, 0);
      check("rst_rdata", host_rdata, 0);
      lost = 0; force_slot = 0; locked = 0; exp_rv = 0; exp_rd = 8'h00;
    end else begin
      if (locked) begin
        host_own = 1; e_gnt = host_req; e_stall = 1;
      end else if (force_slot) begin
        host_own = 1; e_gnt = host_req; e_stall = cpu_req;
      end else begin
        host_own = host_req && !cpu_req; e_gnt = host_own; e_stall = 0;
      end
      e_we   = host_own ? (e_gnt && host_we) : (cpu_req && cpu_we);
      e_addr = host_own ? host_addr : cpu_addr;
      e_wd   = host_own ? host_wdata : cpu_wdata;
      check("gnt", host_gnt, e_gnt);
      check("stall", cpu_stall, e_stall);
      check("mem_we", mem_we, e_we);
      if (e_gnt || cpu_req) check("mem_addr", mem_addr, e_addr);
      if (e_we) check("mem_wdata", mem_wdata, e_wd);
      check("rvalid", host_rvalid, exp_rv);
      check("rdata", host_rdata, exp_rd);
      if (!host_own && cpu_req && !cpu_we) check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
      exp_rv = e_gnt && !host_we;
      if (exp_rv) exp_rd = ref_mem[host_addr];
      if (e_we) ref_mem[e_addr] = e_wd;
      if (locked || force_slot) begin
        lost = 0; force_slot = 0;
      end else if (host_req && cpu_req) begin
        lost++;
        if (lost == LIMIT) begin force_slot = 1; lost = 0; end
      end else begin
        lost = 0;
      end
`ifdef DMEM_ARB_LOCK_EN
      if (locked) locked = host_lock;
      else if (e_gnt && host_lock) locked = 1;
`endif
    end
  end

  task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                       input bit hr, input bit hw, input bit hl, input logic [7:0] ha, input logic [7:0] hd);
    @(posedge clk); #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
  endtask

  initial begin
    logic [9:0] gpat, spat;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 1; host_we = 1; host_lock = 0; host_addr = 8'h10; host_wdata = 8'hA5;
    @(negedge clk);
    check("lit_rst_we", mem_we, 0);
    check("lit_rst_gnt", host_gnt, 0);

    // idle CPU: host write then read back
    drive(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'hA5); rst_n = 1;
    @(negedge clk);
    check("lit_wr_gnt", host_gnt, 1);
    check("lit_wr_we", mem_we, 1);
    check("lit_wr_addr", mem_addr, 8'h10);
    drive(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("lit_rd_valid", host_rvalid, 1);
    check("lit_rd_data", host_rdata, 8'hA5);

    // starvation: host wins every 5th cycle
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h05, 8'h00, 1, 0, 0, 8'h10, 8'h00);
      @(negedge clk);
      gpat[i] = host_gnt;
      spat[i] = cpu_stall;
    end
    check("lit_starve_gnt", gpat, 10'b10_0001_0000);
    check("lit_starve_stall", spat, 10'b10_0001_0000);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    // same-address write collision
    drive(1, 1, 8'h20, 8'h33, 1, 1, 0, 8'h20, 8'h77);
    @(negedge clk);
    check("lit_coll_gnt", host_gnt, 0);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    v = mem[8'h20];
    check("lit_coll_mem", v, 8'h33);

    // lock scenario
    drive(0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h30, 8'h5A);
    @(negedge clk);
    check("lit_lock_gnt", host_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'h31, 8'hEE, 1, 1, 1, 8'h31, 8'h11);
      @(negedge clk);
`ifdef DMEM_ARB_LOCK_EN
      check("lit_lock_stall", cpu_stall, 1);
`else
      check("lit_nolock_stall", cpu_stall, 0);
`endif
    end
    drive(1, 1, 8'h31, 8'hEE, 1, 1, 0, 8'h31, 8'h11);
    drive(1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
`ifdef DMEM_ARB_LOCK_EN
    check("lit_unlock_stall", cpu_stall, 0);
    v = mem[8'h31];
    check("lit_lock_mem", v, 8'h11);
`else
    check("lit_force_stall", cpu_stall, 1);
    v = mem[8'h31];
    check("lit_nolock_mem", v, 8'hEE);
`endif
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    // reset pulsed while the host holds the lock
    drive(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h30, 8'h00);
    drive(1, 0, 8'h31, 8'h00, 1, 0, 1, 8'h30, 8'h00);
    @(negedge clk);
    check("lit_lockrd_valid", host_rvalid, 1);
    check("lit_lockrd_data", host_rdata, 8'h5A);
    drive(1, 0, 8'h31, 8'h00, 1, 0, 1, 8'h30, 8'h00); rst_n = 0;
    @(negedge clk);
    check("lit_rst_lock_stall", cpu_stall, 0);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00); rst_n = 1;
    drive(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("lit_post_rd", host_rdata, 8'h33);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
